// File: rtl/mdu_pkg.sv
// Shared types and sizes for the multi-cycle divider.
package mdu_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p_next_c,
    output logic [WIDTH-1:0] q_next_c
);

    // The partial remainder is WIDTH+1 bits only transiently; between steps its top bit is always zero.
    logic [WIDTH:0] p_sh;
    logic           fits;

    assign p_sh     = {p, q[WIDTH-1]};
    assign fits     = (p_sh >= {1'b0, b});
    assign p_next_c = fits ? WIDTH'(p_sh - {1'b0, b}) : WIDTH'(p_sh);
    assign q_next_c = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/mdu_div.sv
// Radix-2 restoring divider for DIV/DIVU: quotient on quot (LO), remainder on rem (HI).
// Optional exception-flush input abort is built when MDU_DIV_ABORT_EN is defined.
module mdu_div
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MDU_DIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] p_r, p_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [WIDTH-1:0] b_r, b_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             qs, qs_nxt;
    logic             rs, rs_nxt;
    logic [WIDTH-1:0] quot_nxt, rem_nxt;
    logic             dbz_nxt, busy_nxt, done_nxt;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] p_step, q_step;

    mdu_div_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .p        (p_r),
        .q        (q_r),
        .b        (b_r),
        .p_next_c (p_step),
        .q_next_c (q_step)
    );

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            p_r         <= '0;
            q_r         <= '0;
            b_r         <= '0;
            cnt         <= '0;
            qs          <= 1'b0;
            rs          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            p_r         <= p_nxt;
            q_r         <= q_nxt;
            b_r         <= b_nxt;
            cnt         <= cnt_nxt;
            qs          <= qs_nxt;
            rs          <= rs_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            quot        <= quot_nxt;
            rem         <= rem_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_nxt = state;
        p_nxt     = p_r;
        q_nxt     = q_r;
        b_nxt     = b_r;
        cnt_nxt   = cnt;
        qs_nxt    = qs;
        rs_nxt    = rs;
        quot_nxt  = quot;
        rem_nxt   = rem;
        dbz_nxt   = div_by_zero;
        abs_a     = (sign && a[WIDTH-1]) ? WIDTH'(0) - a : a;
        abs_b     = (sign && b[WIDTH-1]) ? WIDTH'(0) - b : b;

        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    if (b == '0) begin
                        // Zero divisor skips the iterations; dividend passes through as remainder.
                        state_nxt = DONE;
                        quot_nxt  = '1;
                        rem_nxt   = a;
                        dbz_nxt   = 1'b1;
                    end else begin
                        state_nxt = CALC;
                        p_nxt     = '0;
                        q_nxt     = abs_a;
                        b_nxt     = abs_b;
                        cnt_nxt   = CNT_W'(WIDTH - 1);
                        qs_nxt    = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rs_nxt    = sign & a[WIDTH-1];
                    end
                end
            end
            CALC: begin
                p_nxt   = p_step;
                q_nxt   = q_step;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
                quot_nxt  = qs ? WIDTH'(0) - q_r : q_r;
                rem_nxt   = rs ? WIDTH'(0) - p_r : p_r;
                dbz_nxt   = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

`ifdef MDU_DIV_ABORT_EN
        // Flush drops the in-flight division and leaves the last results visible.
        if (abort && (state == CALC || state == FIX)) begin
            state_nxt = IDLE;
            quot_nxt  = quot;
            rem_nxt   = rem;
            dbz_nxt   = div_by_zero;
        end
`endif

        busy_nxt = (state_nxt == CALC) || (state_nxt == FIX);
        done_nxt = (state_nxt == DONE);
    end

endmodule
